gate_sweep_checker: RTL and testbench
=====================================

Name: gate_sweep_checker

Overview:
- Self-running, synthesisable exhaustive truth-table checker for the team's 2-input gate blocks; the parametrised successor of the per-gate hand-written stimulus benches.
- Drives every operand combination for a WIDTH-bit, bitwise two-operand gate under test and compares the gate output against an internal reference for a selected operation.
- Accumulates pass/fail and an error count, so any gate (AND/OR/NAND/NOR/XOR/XNOR/NOT/BUF), of any width, can be checked on-chip or in simulation.

Parameters:
- WIDTH, 1, operand width of a, b and y; 1..8.
- DWELL, 1, settle cycles between driving a vector and sampling y_i; ≥1.
- ERR_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- op  in  3  operation: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 BUF a.
- a_o  out  WIDTH  operand a to the gate under test.
- b_o  out  WIDTH  operand b to the gate under test.
- y_i  in  WIDTH  gate-under-test output.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at sweep end.
- pass  out  1  last sweep had zero mismatches.
- err_cnt  out  ERR_W  mismatching vectors in the last or current sweep, saturating.

Behaviour:
- Reset (async assert, sync release): state IDLE, vector index 0, a_o=0, b_o=0, busy=0, done=0, pass=0, err_cnt=0.
- States: IDLE, DRIVE, WAIT, CHECK, DONE.
- IDLE → DRIVE when start=1:
  - latch op into op_q;
  - clear err_cnt and index;
  - pass is cleared to 0 in the same cycle.
- DRIVE, 1 cycle: register a_o=idx[WIDTH-1:0] and b_o=idx[2*WIDTH-1:WIDTH]. Index is 2*WIDTH bits.
- WAIT: exactly DWELL cycles, counted by a dwell counter.
- CHECK, 1 cycle:
  - expected = op_q applied bitwise to a_o, b_o (ops 6/7 ignore b);
  - if y_i != expected, increment err_cnt, saturating at all-ones;
  - if idx is all-ones → DONE, else idx+1 → DRIVE.
- Per-vector cost is 2+DWELL cycles; a full sweep is 2^(2*WIDTH)*(2+DWELL) busy cycles.
- DONE, 1 cycle:
  - done=1;
  - pass = (err_cnt==0), including a mismatch found in the final CHECK;
  - then → IDLE.
- busy=1 exactly in DRIVE, WAIT and CHECK.
- a_o, b_o, err_cnt and pass hold their values in IDLE until the next start.
- start while not in IDLE is ignored. A start held high re-launches from IDLE on the cycle after DONE.
- op changes mid-sweep have no effect, because op_q is used.
- Reset mid-sweep aborts immediately to reset values. No done pulse is issued.
- Index wrap: never wraps; reaching all-ones terminates the sweep.

Optional Feature:
- Macro: GATE_CHK_FAIL_CAPTURE_EN.
- With it defined:
  - extra outputs fail_a (WIDTH), fail_b (WIDTH), fail_y (WIDTH), fail_vld (1);
  - on the first mismatch of a sweep, capture a_o, b_o, y_i and set fail_vld=1;
  - all four are cleared at reset and at start.
- Without it: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package gate_chk_pkg holds:
  - the op encoding constants (OP_AND..OP_BUF);
  - the state enum/localparams;
  - a function gate_ref(op, a, b) returning the expected WIDTH-bit result.
- One natural sub-module, gate_ref_unit: combinational reference model, reusable by other benches.
- FSM and counters stay in the top.

Test Plan:
- Correct NOR, clean sweep. WIDTH=1, DWELL=1, op=3, DUT = correct NOR, start pulse:
  - a_o/b_o step through (0,0),(1,0),(0,1),(1,1);
  - busy high 12 cycles, then done pulse;
  - err_cnt=0, pass=1.
- Stuck-at-0 DUT. Same setup with DUT y=0:
  - err_cnt=1 (only a=0,b=0 expects 1), pass=0;
  - with GATE_CHK_FAIL_CAPTURE_EN: fail_a=0, fail_b=0, fail_y=0, fail_vld=1.
- Wider sweep. WIDTH=2, DWELL=3, op=4, DUT = correct XOR:
  - 16 vectors, busy 80 cycles, err_cnt=0, pass=1.
- Counter saturation. WIDTH=2, ERR_W=2, op=0, DUT = inverted AND:
  - all 16 vectors mismatch, err_cnt=3 (saturated), pass=0.
- Reset abort. Assert rst_n=0 during the 3rd vector:
  - all outputs are at reset values immediately, with no done pulse;
  - the next start sweeps again from a_o=0, b_o=0.
- Ignored start. Pulse start and change op mid-sweep:
  - no restart, the index continues monotonically;
  - the result reflects the originally latched op.

Source files
------------

// File: rtl/gate_sweep_checker_pkg.sv
// rtl/gate_sweep_checker_pkg.sv - op encodings, FSM states and reference gate function
package gate_chk_pkg;

  localparam int GATE_MAX_W = 8;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_BUF  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Operates at the widest supported width; callers zero-extend and slice.
  function automatic logic [GATE_MAX_W-1:0] gate_ref(input op_e op,
                                                     input logic [GATE_MAX_W-1:0] a,
                                                     input logic [GATE_MAX_W-1:0] b);
    logic [GATE_MAX_W-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_NOT:  r = ~a;
      default: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_sweep_checker_if.sv
// rtl/gate_sweep_checker_if.sv - control and gate-under-test bus; GATE_CHK_FAIL_CAPTURE_EN adds fail capture
interface gate_sweep_checker_if #(
  parameter int WIDTH = 1,
  parameter int ERR_W = 16
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a_o;
  logic [WIDTH-1:0] b_o;
  logic [WIDTH-1:0] y_i;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
`ifdef GATE_CHK_FAIL_CAPTURE_EN
  logic [WIDTH-1:0] fail_a;
  logic [WIDTH-1:0] fail_b;
  logic [WIDTH-1:0] fail_y;
  logic             fail_vld;

  modport master (
    input  start, op, y_i,
    output a_o, b_o, busy, done, pass, err_cnt,
    output fail_a, fail_b, fail_y, fail_vld
  );
  modport slave (
    output start, op, y_i,
    input  a_o, b_o, busy, done, pass, err_cnt,
    input  fail_a, fail_b, fail_y, fail_vld
  );
`else
  modport master (
    input  start, op, y_i,
    output a_o, b_o, busy, done, pass, err_cnt
  );
  modport slave (
    output start, op, y_i,
    input  a_o, b_o, busy, done, pass, err_cnt
  );
`endif
endinterface

// File: rtl/gate_sweep_checker_ref_unit.sv
// rtl/gate_sweep_checker_ref_unit.sv - combinational reference gate, WIDTH bits wide
module gate_ref_unit
  import gate_chk_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  logic [GATE_MAX_W-1:0] full;
  logic                  unused_hi;

  assign full      = gate_ref(op, GATE_MAX_W'(a), GATE_MAX_W'(b));
  assign y         = full[WIDTH-1:0];
  assign unused_hi = ^full;
endmodule

// File: rtl/gate_sweep_checker.sv
// rtl/gate_sweep_checker.sv - exhaustive 2-input gate sweep checker; GATE_CHK_FAIL_CAPTURE_EN adds first-fail capture
module gate_sweep_checker
  import gate_chk_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DWELL = 1,
  parameter int ERR_W = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  gate_sweep_checker_if.master bus
);
  localparam int IDX_W = 2 * WIDTH;
  localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

  state_e           state;
  op_e              op_q;
  logic [IDX_W-1:0] idx;
  logic [DW_W-1:0]  dwell_cnt;
  logic [WIDTH-1:0] expected;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  gate_ref_unit #(.WIDTH(WIDTH)) u_ref (
    .op (op_q),
    .a  (bus.a_o),
    .b  (bus.b_o),
    .y  (expected)
  );

  assign mismatch = (bus.y_i != expected);
  assign err_next = (mismatch && (bus.err_cnt != '1)) ? bus.err_cnt + 1'b1 : bus.err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op_q        <= OP_AND;
      idx         <= '0;
      dwell_cnt   <= '0;
      bus.a_o     <= '0;
      bus.b_o     <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.pass    <= 1'b0;
      bus.err_cnt <= '0;
`ifdef GATE_CHK_FAIL_CAPTURE_EN
      bus.fail_a   <= '0;
      bus.fail_b   <= '0;
      bus.fail_y   <= '0;
      bus.fail_vld <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_q        <= op_e'(bus.op);
            idx         <= '0;
            bus.err_cnt <= '0;
            bus.pass    <= 1'b0;
            bus.busy    <= 1'b1;
            state       <= S_DRIVE;
`ifdef GATE_CHK_FAIL_CAPTURE_EN
            bus.fail_a   <= '0;
            bus.fail_b   <= '0;
            bus.fail_y   <= '0;
            bus.fail_vld <= 1'b0;
`endif
          end
        end
        S_DRIVE: begin
          bus.a_o   <= idx[WIDTH-1:0];
          bus.b_o   <= idx[IDX_W-1:WIDTH];
          dwell_cnt <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (dwell_cnt == DW_W'(DWELL - 1)) state <= S_CHECK;
          else dwell_cnt <= dwell_cnt + 1'b1;
        end
        S_CHECK: begin
          bus.err_cnt <= err_next;
`ifdef GATE_CHK_FAIL_CAPTURE_EN
          if (mismatch && !bus.fail_vld) begin
            bus.fail_a   <= bus.a_o;
            bus.fail_b   <= bus.b_o;
            bus.fail_y   <= bus.y_i;
            bus.fail_vld <= 1'b1;
          end
`endif
          // pass uses err_next so a mismatch on the final vector is counted
          if (idx == '1) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.pass <= (err_next == '0);
            state    <= S_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_DRIVE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb/tb_gate_sweep_checker.sv - randomized self-checking bench for gate_sweep_checker
module tb_gate_sweep_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gate_sweep_checker_if #(.WIDTH(1), .ERR_W(16)) if1 ();
  gate_sweep_checker_if #(.WIDTH(2), .ERR_W(2))  if2 ();

  gate_sweep_checker #(.WIDTH(1), .DWELL(1), .ERR_W(16)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  gate_sweep_checker #(.WIDTH(2), .DWELL(3), .ERR_W(2))  u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  int n_tests = 0;
  int n_fail  = 0;

  logic            sel = 1'b0;
  logic            start_r = 1'b0;
  logic [2:0]      op_r = 3'd0;
  int              gate_op = 0;
  int              gate_mode = 0;
  logic [15:0][1:0] corrupt = '0;

  function automatic logic [1:0] ref_gate(int op, logic [1:0] a, logic [1:0] b, int w);
    logic [1:0] m, r;
    m = (w == 1) ? 2'b01 : 2'b11;
    case (op)
      0: r = a & b;
      1: r = a | b;
      2: r = ~(a & b);
      3: r = ~(a | b);
      4: r = a ^ b;
      5: r = ~(a ^ b);
      6: r = ~a;
      default: r = a;
    endcase
    return r & m;
  endfunction

  // mode 0: correct gate xor a per-vector fault mask, 1: stuck-at-0, 2: inverted output
  function automatic logic [1:0] gut(int w, int op, int mode, logic [1:0] mask, logic [1:0] a, logic [1:0] b);
    logic [1:0] m, r;
    m = (w == 1) ? 2'b01 : 2'b11;
    r = ref_gate(op, a, b, w);
    case (mode)
      1: r = 2'b00;
      2: r = ~r & m;
      default: r = (r ^ mask) & m;
    endcase
    return r;
  endfunction

  logic [1:0] y1_full;
  assign y1_full   = gut(1, gate_op, gate_mode, corrupt[{2'b00, if1.b_o, if1.a_o}], {1'b0, if1.a_o}, {1'b0, if1.b_o});
  assign if1.y_i   = y1_full[0];
  assign if2.y_i   = gut(2, gate_op, gate_mode, corrupt[{if2.b_o, if2.a_o}], if2.a_o, if2.b_o);
  assign if1.start = start_r & ~sel;
  assign if2.start = start_r & sel;
  assign if1.op    = op_r;
  assign if2.op    = op_r;

  logic [1:0]  obs_a, obs_b;
  logic        obs_busy, obs_done, obs_pass;
  logic [15:0] obs_err;
  assign obs_a    = sel ? if2.a_o : {1'b0, if1.a_o};
  assign obs_b    = sel ? if2.b_o : {1'b0, if1.b_o};
  assign obs_busy = sel ? if2.busy : if1.busy;
  assign obs_done = sel ? if2.done : if1.done;
  assign obs_pass = sel ? if2.pass : if1.pass;
  assign obs_err  = sel ? {14'b0, if2.err_cnt} : if1.err_cnt;
`ifdef GATE_CHK_FAIL_CAPTURE_EN
  logic [1:0] obs_fa, obs_fb, obs_fy;
  logic       obs_fv;
  assign obs_fa = sel ? if2.fail_a : {1'b0, if1.fail_a};
  assign obs_fb = sel ? if2.fail_b : {1'b0, if1.fail_b};
  assign obs_fy = sel ? if2.fail_y : {1'b0, if1.fail_y};
  assign obs_fv = sel ? if2.fail_vld : if1.fail_vld;
`endif

  // Full sweep on the selected checker; disturb>=0 pulses start and changes op at that busy cycle.
  task automatic run_sweep(input string name, input int op, input int mode, input int disturb);
    int w, d, per, nvec, errmax, cnt, k, seq_bad, first_v, idle_gap;
    logic [1:0] wm, first_y, a, b, good, got;
    bit seen_done;
    w = sel ? 2 : 1;
    d = sel ? 3 : 1;
    errmax = sel ? 3 : 65535;
    wm = (w == 1) ? 2'b01 : 2'b11;
    per = 2 + d;
    nvec = 1 << (2 * w);
    gate_op = op;
    gate_mode = mode;
    op_r = 3'(op);
    cnt = 0;
    first_v = -1;
    first_y = 0;
    for (int v = 0; v < nvec; v++) begin
      a = 2'(v) & wm;
      b = 2'(v >> w) & wm;
      good = ref_gate(op, a, b, w);
      got = gut(w, op, mode, corrupt[v], a, b);
      if (got != good) begin
        cnt++;
        if (first_v < 0) begin first_v = v; first_y = got; end
      end
    end
    if (cnt > errmax) cnt = errmax;

    start_r = 1'b1;
    k = 0; seq_bad = 0; idle_gap = 0; seen_done = 0;
    for (int c = 0; c < 4000 && !seen_done; c++) begin
      @(negedge clk);
      start_r = 1'b0;
      if (obs_done) seen_done = 1;
      else if (obs_busy) begin
        if ((k % per) != 0 && (obs_a !== (2'(k / per) & wm) || obs_b !== (2'((k / per) >> w) & wm)))
          seq_bad++;
        k++;
        if (k == disturb) begin
          start_r = 1'b1;
          op_r = 3'((op + 1) % 8);
        end
      end else idle_gap++;
    end
    n_tests++;
    if (!seen_done) begin
      n_fail++;
      $display("FAIL %s timeout: no done pulse within 4000 cycles", name);
      return;
    end
    n_tests++;
    if (seq_bad !== 0 || idle_gap !== 0) begin
      n_fail++;
      $display("FAIL %s vector sequence: %0d bad steps, %0d idle gaps, required 0/0", name, seq_bad, idle_gap);
    end
    n_tests++;
    if (k !== nvec * per) begin
      n_fail++;
      $display("FAIL %s busy cycles: got %0d, required %0d", name, k, nvec * per);
    end
    n_tests++;
    if (obs_busy !== 1'b0 || obs_err !== 16'(cnt) || obs_pass !== (cnt == 0)) begin
      n_fail++;
      $display("FAIL %s result: busy=%b err=%0d pass=%b, required busy=0 err=%0d pass=%b",
               name, obs_busy, obs_err, obs_pass, cnt, cnt == 0);
    end
`ifdef GATE_CHK_FAIL_CAPTURE_EN
    n_tests++;
    if (first_v < 0) begin
      if (obs_fv !== 1'b0) begin
        n_fail++;
        $display("FAIL %s fail_vld: got %b, required 0", name, obs_fv);
      end
    end else if (obs_fv !== 1'b1 || obs_fa !== (2'(first_v) & wm) ||
                 obs_fb !== (2'(first_v >> w) & wm) || obs_fy !== first_y) begin
      n_fail++;
      $display("FAIL %s capture: vld=%b a=%0d b=%0d y=%0d, required 1 %0d %0d %0d", name, obs_fv,
               obs_fa, obs_fb, obs_fy, 2'(first_v) & wm, 2'(first_v >> w) & wm, first_y);
    end
`endif
    @(negedge clk);
    n_tests++;
    if (obs_done !== 1'b0 || obs_a !== wm || obs_b !== wm || obs_err !== 16'(cnt) || obs_pass !== (cnt == 0)) begin
      n_fail++;
      $display("FAIL %s hold after done: done=%b a=%0d b=%0d err=%0d pass=%b", name,
               obs_done, obs_a, obs_b, obs_err, obs_pass);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      n_tests++;
      if (obs_a !== 0 || obs_b !== 0 || obs_busy !== 0 || obs_done !== 0 || obs_pass !== 0 || obs_err !== 0) begin
        n_fail++;
        $display("FAIL reset[%0d]: a=%0d b=%0d busy=%b done=%b pass=%b err=%0d, required all 0",
                 s, obs_a, obs_b, obs_busy, obs_done, obs_pass, obs_err);
      end
    end
  endtask

  task automatic test_nor_clean();
    sel = 0; corrupt = '0;
    run_sweep("nor_clean", 3, 0, -1);
  endtask

  task automatic test_stuck0();
    sel = 0; corrupt = '0;
    run_sweep("nor_stuck0", 3, 1, -1);
  endtask

  task automatic test_xor_wide();
    sel = 1; corrupt = '0;
    run_sweep("xor_wide", 4, 0, -1);
  endtask

  task automatic test_saturation();
    sel = 1; corrupt = '0;
    run_sweep("and_saturate", 0, 2, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      sel = 1'($urandom_range(0, 1));
      for (int v = 0; v < 16; v++)
        corrupt[v] = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      run_sweep($sformatf("random%0d", i), int'($urandom_range(0, 7)), 0, -1);
    end
    corrupt = '0;
  endtask

  task automatic test_reset_abort();
    int k;
    bit saw_done;
    sel = 1; corrupt = '0;
    gate_op = 4; gate_mode = 0; op_r = 3'd4;
    start_r = 1'b1;
    k = 0; saw_done = 0;
    for (int c = 0; c < 200 && k < 2 * 5 + 3; c++) begin
      @(negedge clk);
      start_r = 1'b0;
      if (obs_busy) k++;
      if (obs_done) saw_done = 1;
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (obs_a !== 0 || obs_b !== 0 || obs_busy !== 0 || obs_done !== 0 || obs_pass !== 0 || obs_err !== 0) begin
      n_fail++;
      $display("FAIL reset_abort: a=%0d b=%0d busy=%b done=%b pass=%b err=%0d, required all 0",
               obs_a, obs_b, obs_busy, obs_done, obs_pass, obs_err);
    end
    repeat (3) begin
      @(negedge clk);
      if (obs_done) saw_done = 1;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (obs_done) saw_done = 1;
    end
    n_tests++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort done pulse: got 1, required 0");
    end
    run_sweep("after_abort", 4, 0, -1);
  endtask

  task automatic test_ignored_start();
    sel = 1; corrupt = '0;
    run_sweep("ignored_start", 4, 0, 23);
    sel = 0;
    run_sweep("ignored_start_w1", 1, 0, 5);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_nor_clean();
    test_stuck0();
    test_xor_wide();
    test_saturation();
    test_reset_abort();
    test_ignored_start();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
